stack_sequencer: RTL and testbench

- Executes the multi-cycle stack transfers requested by the CPU controller FSM while it sits in its stack-operation state (JSR, RTS, RTI, interrupt entry).
- Owns the stack pointer (SP) and supplies the data-memory address and write data for each stack byte.
- Captures the popped PC and flags, and raises `stack_op_end` back to the controller.
- The controller drives `data_mem_wr`/`data_mem_rd`/`bus_req`. This block muxes only address and data, and sequences on `bus_grant`.

---
 rtl/stack_sequencer.sv | 135 +++++++++++++
 tb/tb_stack_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
// Stack transfer sequencer: walks the two stack bytes of a JSR/RTS/RTI/interrupt
// operation, owns the stack pointer and captures the popped PC and flags.
module stack_sequencer #(
   parameter logic [7:0] SP_INIT  = 8'h7F,
   parameter logic [7:0] SP_LIMIT = 8'h60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stack_op_ongoing,
   input  logic       push_or_pop,
   input  logic       bus_grant,
   input  logic [7:0] push_pc,
   input  logic [5:0] push_flags,
   input  logic [7:0] mem_rdata,
   output logic [7:0] stack_addr,
   output logic [7:0] stack_wdata,
   output logic       stack_op_end,
   output logic [7:0] pop_pc,
   output logic [5:0] pop_flags,
   output logic [7:0] sp,
   output logic       stack_err
);

   localparam int unsigned AW = 8;
   localparam int unsigned FW = 6;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BYTE0 = 2'd1;
   localparam logic [1:0] BYTE1 = 2'd2;

   logic [1:0]    state, state_next;
   logic          dir, dir_next;
   logic [AW-1:0] sp_next, sp_dec, sp_inc;
   logic          dec_wrap, inc_wrap;
   logic          err_next;
   logic [AW-1:0] pop_pc_next;
   logic [FW-1:0] pop_flags_next;
   logic          cur_push;

   // SP moves only inside [SP_LIMIT, SP_INIT]; leaving the window wraps around
   assign dec_wrap = (sp == SP_LIMIT);
   assign inc_wrap = (sp == SP_INIT);
   assign sp_dec   = dec_wrap ? SP_INIT  : AW'(sp - AW'(1));
   assign sp_inc   = inc_wrap ? SP_LIMIT : AW'(sp + AW'(1));

   // Live direction in the start cycle so BYTE0 address/data are already valid
   assign cur_push = (state == IDLE) ? push_or_pop : dir;

   always_comb begin
      state_next     = state;
      dir_next       = dir;
      sp_next        = sp;
      err_next       = stack_err;
      pop_pc_next    = pop_pc;
      pop_flags_next = pop_flags;
      stack_op_end   = 1'b0;
      stack_addr     = cur_push ? sp : sp_inc;
      stack_wdata    = '0;

      if (cur_push) begin
         stack_wdata = (state == BYTE1) ? {2'b00, push_flags} : push_pc;
      end
      if ((state == IDLE) && !stack_op_ongoing) begin
         stack_addr  = sp;
         stack_wdata = '0;
      end

      case (state)
         IDLE: begin
            if (stack_op_ongoing) begin
               dir_next   = push_or_pop;
               state_next = BYTE0;
            end
         end
         BYTE0: begin
            if (!stack_op_ongoing) begin
               state_next = IDLE;
            end else if (bus_grant) begin
               state_next = BYTE1;
               if (dir) begin
                  sp_next  = sp_dec;
                  err_next = stack_err | dec_wrap;
               end else begin
                  sp_next        = sp_inc;
                  err_next       = stack_err | inc_wrap;
                  pop_flags_next = mem_rdata[FW-1:0];
               end
            end
         end
         BYTE1: begin
            if (!stack_op_ongoing) begin
               state_next = IDLE;
            end else if (bus_grant) begin
               state_next   = IDLE;
               stack_op_end = 1'b1;
               if (dir) begin
                  sp_next  = sp_dec;
                  err_next = stack_err | dec_wrap;
               end else begin
                  sp_next     = sp_inc;
                  err_next    = stack_err | inc_wrap;
                  pop_pc_next = mem_rdata;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // Reset dominates a same-cycle grant, including the completion strobe
      if (!rst) begin
         stack_addr   = SP_INIT;
         stack_wdata  = '0;
         stack_op_end = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         dir       <= 1'b0;
         sp        <= SP_INIT;
         stack_err <= 1'b0;
         pop_pc    <= '0;
         pop_flags <= '0;
      end else begin
         state     <= state_next;
         dir       <= dir_next;
         sp        <= sp_next;
         stack_err <= err_next;
         pop_pc    <= pop_pc_next;
         pop_flags <= pop_flags_next;
      end
   end

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: expected stack transfers are queued when an
// op is launched and compared as each byte is granted.
module tb_stack_sequencer;

   localparam logic [7:0] SP_INIT  = 8'h7F;
   localparam logic [7:0] SP_LIMIT = 8'h60;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
      logic       wr;
   } xfer_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       stack_op_ongoing;
   logic       push_or_pop;
   logic       bus_grant;
   logic [7:0] push_pc;
   logic [5:0] push_flags;
   logic [7:0] mem_rdata;
   logic [7:0] stack_addr;
   logic [7:0] stack_wdata;
   logic       stack_op_end;
   logic [7:0] pop_pc;
   logic [5:0] pop_flags;
   logic [7:0] sp;
   logic       stack_err;

   int checks = 0;
   int errors = 0;

   xfer_t      sbq[$];
   logic [7:0] mem [256];
   logic [7:0] msp;
   logic       merr;
   logic [7:0] exp_pc;
   logic [5:0] exp_flags;

   always #5 clk = ~clk;

   stack_sequencer #(.SP_INIT(SP_INIT), .SP_LIMIT(SP_LIMIT)) dut (
      .clk              (clk),
      .rst              (rst),
      .stack_op_ongoing (stack_op_ongoing),
      .push_or_pop      (push_or_pop),
      .bus_grant        (bus_grant),
      .push_pc          (push_pc),
      .push_flags       (push_flags),
      .mem_rdata        (mem_rdata),
      .stack_addr       (stack_addr),
      .stack_wdata      (stack_wdata),
      .stack_op_end     (stack_op_end),
      .pop_pc           (pop_pc),
      .pop_flags        (pop_flags),
      .sp               (sp),
      .stack_err        (stack_err)
   );

   function automatic logic [7:0] m_inc(input logic [7:0] v);
      return (v == SP_INIT) ? SP_LIMIT : 8'(v + 8'd1);
   endfunction

   function automatic logic [7:0] m_dec(input logic [7:0] v);
      return (v == SP_LIMIT) ? SP_INIT : 8'(v - 8'd1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete stack op; keep=1 leaves ongoing high so the next op starts back-to-back
   task automatic run_op(input logic push, input logic [7:0] pc, input logic [5:0] fl,
                         input int waits, input logic toggle, input logic keep);
      xfer_t e;
      @(negedge clk);
      stack_op_ongoing = 1'b1;
      push_or_pop      = push;
      push_pc          = pc;
      push_flags       = fl;
      bus_grant        = 1'b1;
      #1;
      chk("start_addr", stack_addr, push ? msp : m_inc(msp));
      chk("start_wdata", stack_wdata, push ? {24'd0, pc} : 32'd0);
      chk("start_end", stack_op_end, 0);
      for (int b = 0; b < 2; b++) begin
         e.addr = push ? msp : m_inc(msp);
         e.wr   = push;
         e.data = push ? ((b == 0) ? pc : {2'b00, fl}) : 8'h00;
         sbq.push_back(e);
         for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            bus_grant = 1'b0;
            if (toggle && b == 1) push_or_pop = ~push;
            #1;
            chk("wait_addr", stack_addr, e.addr);
            chk("wait_end", stack_op_end, 0);
            chk("wait_sp", sp, msp);
         end
         @(negedge clk);
         bus_grant = 1'b1;
         e = sbq.pop_front();
         if (!push) mem_rdata = mem[e.addr];
         #1;
         chk("grant_addr", stack_addr, e.addr);
         chk("grant_wdata", stack_wdata, e.data);
         chk("grant_end", stack_op_end, (b == 1) ? 1 : 0);
         if (push) begin
            mem[e.addr] = e.data;
            if (msp == SP_LIMIT) merr = 1'b1;
            msp = m_dec(msp);
         end else begin
            if (msp == SP_INIT) merr = 1'b1;
            if (b == 0) exp_flags = mem[e.addr][5:0];
            else        exp_pc    = mem[e.addr];
            msp = m_inc(msp);
         end
      end
      if (!keep) begin
         @(negedge clk);
         stack_op_ongoing = 1'b0;
         bus_grant        = 1'b0;
         push_or_pop      = 1'b0;
         #1;
         chk("after_sp", sp, msp);
         chk("after_err", stack_err, merr);
         chk("after_end", stack_op_end, 0);
         chk("after_pop_pc", pop_pc, exp_pc);
         chk("after_pop_flags", pop_flags, exp_flags);
         chk("after_idle_addr", stack_addr, msp);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      msp              = SP_INIT;
      merr             = 1'b0;
      exp_pc           = 8'h00;
      exp_flags        = 6'h00;
      rst              = 1'b0;
      stack_op_ongoing = 1'b0;
      push_or_pop      = 1'b0;
      bus_grant        = 1'b0;
      push_pc          = 8'h00;
      push_flags       = 6'h00;
      mem_rdata        = 8'h00;

      // Reset for two cycles
      repeat (2) @(negedge clk);
      #1;
      chk("rst_sp", sp, 8'h7F);
      chk("rst_err", stack_err, 0);
      chk("rst_end", stack_op_end, 0);
      chk("rst_pop_pc", pop_pc, 0);
      chk("rst_pop_flags", pop_flags, 0);
      chk("rst_addr", stack_addr, 8'h7F);
      chk("rst_wdata", stack_wdata, 0);
      @(negedge clk);
      rst = 1'b1;

      // Push with grant every cycle, then pop it back with two wait states per byte
      run_op(1'b1, 8'h3C, 6'b100101, 0, 1'b0, 1'b0);
      chk("push_sp", sp, 8'h7D);
      run_op(1'b0, 8'h00, 6'h00, 2, 1'b0, 1'b0);
      chk("pop_flags_val", pop_flags, 6'b100101);
      chk("pop_pc_val", pop_pc, 8'h3C);
      chk("pop_sp", sp, 8'h7F);

      // Direction toggled mid-op must not turn the push into a pop
      run_op(1'b1, 8'hA5, 6'h1A, 1, 1'b1, 1'b0);
      chk("latch_sp", sp, 8'h7D);
      run_op(1'b0, 8'h00, 6'h00, 0, 1'b0, 1'b0);
      chk("latch_pop_pc", pop_pc, 8'hA5);

      // Sixteen back-to-back pushes fill the stack and wrap SP
      for (int i = 0; i < 16; i++) begin
         run_op(1'b1, 8'(i + 8'h40), 6'(i), 0, 1'b0, (i != 15) ? 1'b1 : 1'b0);
      end
      chk("ovf_last_write", mem[SP_LIMIT], {2'b00, 6'(15)});
      chk("ovf_sp", sp, 8'h7F);
      chk("ovf_err", stack_err, 1);

      // Abort after the first byte of a push
      @(negedge clk);
      stack_op_ongoing = 1'b1;
      push_or_pop      = 1'b1;
      push_pc          = 8'h11;
      bus_grant        = 1'b0;
      @(negedge clk);
      bus_grant = 1'b1;
      #1;
      chk("abort_b0_addr", stack_addr, 8'h7F);
      @(negedge clk);
      stack_op_ongoing = 1'b0;
      bus_grant        = 1'b0;
      #1;
      chk("abort_end", stack_op_end, 0);
      @(negedge clk);
      #1;
      chk("abort_sp", sp, 8'h7E);
      chk("abort_idle_addr", stack_addr, 8'h7E);
      chk("abort_err_sticky", stack_err, 1);

      // Reset arriving together with the final grant
      @(negedge clk);
      stack_op_ongoing = 1'b1;
      push_or_pop      = 1'b1;
      @(negedge clk);
      bus_grant = 1'b1;
      #1;
      chk("rstmid_b0_addr", stack_addr, 8'h7E);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstmid_end", stack_op_end, 0);
      @(negedge clk);
      rst              = 1'b1;
      stack_op_ongoing = 1'b0;
      bus_grant        = 1'b0;
      #1;
      chk("rstmid_sp", sp, 8'h7F);
      chk("rstmid_err", stack_err, 0);
      chk("rstmid_pop_pc", pop_pc, 0);
      chk("rstmid_pop_flags", pop_flags, 0);
      chk("rstmid_end_idle", stack_op_end, 0);
      chk("sb_empty", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
